// File: rtl/keyword_match_pkg.sv
// Shared types and byte helpers for the multi-keyword text matcher.
package keyword_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MATCHING = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  // Helpers work on a fixed maximum width; callers pass the live byte count.
  localparam int unsigned KW_MAX_BYTES = 64;
  localparam int unsigned KW_MAX_BITS  = KW_MAX_BYTES * 8;
  localparam int unsigned KW_LEN_W     = 7;

  function automatic logic [7:0] to_lower_byte(input logic [7:0] b);
    logic [7:0] r;
    if (b >= 8'h41 && b <= 8'h5A) r = b | 8'h20;
    else                          r = b;
    return r;
  endfunction

  function automatic logic [KW_MAX_BITS-1:0] byte_reverse(input logic [KW_MAX_BITS-1:0] x,
                                                          input int unsigned nbytes);
    logic [KW_MAX_BITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < KW_MAX_BYTES; i++) begin
      if (i < nbytes) r[i*8 +: 8] = x[(nbytes-1-i)*8 +: 8];
    end
    return r;
  endfunction

  // Keyword stores its first character in the MS byte of an nbytes-wide field.
  function automatic logic [KW_LEN_W-1:0] kw_length(input logic [KW_MAX_BITS-1:0] kw,
                                                    input int unsigned nbytes);
    logic [KW_MAX_BITS-1:0] rev;
    logic [KW_LEN_W-1:0]    len;
    logic                   found;
    rev   = byte_reverse(kw, nbytes);
    len   = nbytes[KW_LEN_W-1:0];
    found = 1'b0;
    for (int unsigned i = 0; i < KW_MAX_BYTES; i++) begin
      if (i < nbytes && !found && rev[i*8 +: 8] == 8'h00) begin
        len   = KW_LEN_W'(i);
        found = 1'b1;
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/keyword_window_cmp.sv
// Combinational check of one keyword against every valid lane of the
// history+beat window; window byte 0 is the oldest byte.
module keyword_window_cmp
  import keyword_match_pkg::*;
#(
  parameter int KW_BYTES   = 16,
  parameter int KEEP_WIDTH = 8,
  parameter int HIST       = 15
) (
  input  logic [KW_BYTES*8-1:0]          keyword_i,
  input  logic [KW_LEN_W-1:0]            kw_len_i,
  input  logic [(HIST+KEEP_WIDTH)*8-1:0] window_i,
  input  logic [KEEP_WIDTH-1:0]          tkeep_i,
  output logic                           match_o
);

  int                    shamt_s;
  logic [KW_BYTES*8-1:0] aligned_s;
  logic                  lane_ok_s;

  // Right-align the keyword so byte j is the character j positions before its end.
  always_comb begin
    shamt_s   = (KW_BYTES - int'(kw_len_i)) * 8;
    aligned_s = keyword_i >> shamt_s;
    match_o   = 1'b0;
    lane_ok_s = 1'b0;
    for (int p = 0; p < KEEP_WIDTH; p++) begin
      lane_ok_s = tkeep_i[p] & (kw_len_i != '0);
      for (int j = 0; j < KW_BYTES; j++) begin
        if (j < int'(kw_len_i))
          lane_ok_s = lane_ok_s & (window_i[(HIST+p-j)*8 +: 8] == aligned_s[j*8 +: 8]);
        else
          lane_ok_s = lane_ok_s;
      end
      match_o = match_o | lane_ok_s;
    end
  end

endmodule

// File: rtl/keyword_match_multi.sv
// Scans one AXI-Stream text frame against NUM_KW keywords and returns a
// registered allow/deny verdict with the lowest matching keyword index.
module keyword_match_multi
  import keyword_match_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
  parameter int KW_BYTES         = 16,
  parameter int NUM_KW           = 4,
  parameter int CASE_INSENSITIVE = 1
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [NUM_KW*KW_BYTES*8-1:0]                keywords,
  input  logic [NUM_KW-1:0]                           kw_enable,
  input  logic [DATA_WIDTH-1:0]                       s_axis_text_tdata,
  input  logic [KEEP_WIDTH-1:0]                       s_axis_text_tkeep,
  input  logic                                        s_axis_text_tvalid,
  output logic                                        s_axis_text_tready,
  input  logic                                        s_axis_text_tlast,
  input  logic                                        s_axis_text_tuser,
  output logic                                        allow_sig,
  output logic                                        deny_sig,
  output logic [((NUM_KW > 1) ? $clog2(NUM_KW) : 1)-1:0] match_id,
  output logic                                        match_err,
  input  logic                                        ack
);

  localparam int ID_W      = (NUM_KW > 1) ? $clog2(NUM_KW) : 1;
  localparam int HIST      = (KW_BYTES > 1) ? KW_BYTES - 1 : 1;
  localparam int WIN_BYTES = HIST + KEEP_WIDTH;
  localparam int KWB       = KW_BYTES * 8;

  state_e                     state_q;
  logic                       tready_q, allow_q, deny_q, err_q;
  logic [ID_W-1:0]            id_q;
  logic [HIST*8-1:0]          hist_q, hist_eff_s, hist_next_s;
  logic [NUM_KW*KWB-1:0]      kw_q, kw_eff_s;
  logic [NUM_KW*KW_LEN_W-1:0] len_q, len_live_s, len_eff_s;
  logic [NUM_KW-1:0]          en_q, en_eff_s, hit_s, match_s;
  logic [KEEP_WIDTH*8-1:0]    beat_s;
  logic [WIN_BYTES*8-1:0]     win_s;
  int unsigned                keep_cnt_s;
  logic [ID_W-1:0]            first_id_s;
  logic                       match_any_s, hs_s, ack_ok_s, in_idle_s;

  assign hs_s      = s_axis_text_tvalid & tready_q;
  assign ack_ok_s  = ack & (allow_q | deny_q);
  assign in_idle_s = (state_q == ST_IDLE);

  // Fold the beat, build the window and the history seen by the next beat.
  always_comb begin
    beat_s = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      if (CASE_INSENSITIVE != 0) beat_s[j*8 +: 8] = to_lower_byte(s_axis_text_tdata[j*8 +: 8]);
      else                       beat_s[j*8 +: 8] = s_axis_text_tdata[j*8 +: 8];
    end
    hist_eff_s = in_idle_s ? '0 : hist_q;
    win_s      = {beat_s, hist_eff_s};
    keep_cnt_s = 32'd0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      keep_cnt_s = keep_cnt_s + (s_axis_text_tkeep[j] ? 32'd1 : 32'd0);
    end
    hist_next_s = '0;
    for (int unsigned i = 0; i < HIST; i++) begin
      hist_next_s[i*8 +: 8] = win_s[(i+keep_cnt_s)*8 +: 8];
    end
  end

  // The first beat of a frame is judged against the live keyword inputs.
  for (genvar k = 0; k < NUM_KW; k++) begin : g_kw
    logic [KW_MAX_BITS-1:0] kw_ext_s;
    assign kw_ext_s = KW_MAX_BITS'(keywords[k*KWB +: KWB]);
    assign len_live_s[k*KW_LEN_W +: KW_LEN_W] = kw_length(kw_ext_s, KW_BYTES);
    assign kw_eff_s[k*KWB +: KWB] = in_idle_s ? keywords[k*KWB +: KWB] : kw_q[k*KWB +: KWB];
    assign len_eff_s[k*KW_LEN_W +: KW_LEN_W] = in_idle_s ? len_live_s[k*KW_LEN_W +: KW_LEN_W]
                                                         : len_q[k*KW_LEN_W +: KW_LEN_W];
    assign en_eff_s[k] = in_idle_s ? kw_enable[k] : en_q[k];

    keyword_window_cmp #(
      .KW_BYTES   (KW_BYTES),
      .KEEP_WIDTH (KEEP_WIDTH),
      .HIST       (HIST)
    ) u_cmp (
      .keyword_i (kw_eff_s[k*KWB +: KWB]),
      .kw_len_i  (len_eff_s[k*KW_LEN_W +: KW_LEN_W]),
      .window_i  (win_s),
      .tkeep_i   (s_axis_text_tkeep),
      .match_o   (hit_s[k])
    );

    assign match_s[k] = hit_s[k] & en_eff_s[k] & (len_eff_s[k*KW_LEN_W +: KW_LEN_W] != '0);
  end

  // Lowest matching keyword index wins.
  always_comb begin
    match_any_s = |match_s;
    first_id_s  = '0;
    for (int k = NUM_KW - 1; k >= 0; k--) begin
      first_id_s = match_s[k] ? ID_W'(k) : first_id_s;
    end
  end

  // Frame FSM, keyword capture, history and verdict registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tready_q <= 1'b0;
      allow_q  <= 1'b0;
      deny_q   <= 1'b0;
      err_q    <= 1'b0;
      id_q     <= '0;
      hist_q   <= '0;
      kw_q     <= '0;
      len_q    <= '0;
      en_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_MATCHING: begin
          tready_q <= 1'b1;
          if (hs_s) begin
            if (in_idle_s) begin
              kw_q  <= keywords;
              len_q <= len_live_s;
              en_q  <= kw_enable;
            end
            hist_q <= hist_next_s;
            if (s_axis_text_tuser || match_any_s) begin
              deny_q <= 1'b1;
              err_q  <= s_axis_text_tuser;
              id_q   <= s_axis_text_tuser ? {ID_W{1'b0}} : first_id_s;
              if (s_axis_text_tlast) begin
                state_q  <= ST_HOLD;
                tready_q <= 1'b0;
              end else begin
                state_q <= ST_DRAIN;
              end
            end else if (s_axis_text_tlast) begin
              allow_q  <= 1'b1;
              state_q  <= ST_HOLD;
              tready_q <= 1'b0;
            end else begin
              state_q <= ST_MATCHING;
            end
          end
        end
        ST_DRAIN: begin
          tready_q <= 1'b1;
          if (ack_ok_s) begin
            deny_q <= 1'b0;
            err_q  <= 1'b0;
            id_q   <= '0;
          end
          if (hs_s && s_axis_text_tlast) begin
            if (deny_q && !ack_ok_s) begin
              state_q  <= ST_HOLD;
              tready_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          tready_q <= 1'b0;
          if (ack_ok_s) begin
            allow_q  <= 1'b0;
            deny_q   <= 1'b0;
            err_q    <= 1'b0;
            id_q     <= '0;
            state_q  <= ST_IDLE;
            tready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          tready_q <= 1'b0;
          allow_q  <= 1'b0;
          deny_q   <= 1'b0;
          err_q    <= 1'b0;
          id_q     <= '0;
        end
      endcase
    end
  end

  assign s_axis_text_tready = tready_q;
  assign allow_sig          = allow_q;
  assign deny_sig           = deny_q;
  assign match_id           = id_q;
  assign match_err          = err_q;

endmodule

// File: tb/tb_keyword_match_multi.sv
// Directed bench: two instances (case-insensitive and case-sensitive) share stimulus.
module tb_keyword_match_multi;

  logic         clk;
  logic         reset_n;
  logic [511:0] keywords;
  logic [3:0]   kw_enable;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tvalid, tlast, tuser, ack;
  logic         tready_a, allow_a, deny_a, err_a;
  logic [1:0]   id_a;
  logic         tready_b, allow_b, deny_b, err_b;
  logic [1:0]   id_b;

  int checks   = 0;
  int failures = 0;

  keyword_match_multi #(.CASE_INSENSITIVE(1)) dut (
    .clk(clk), .reset_n(reset_n), .keywords(keywords), .kw_enable(kw_enable),
    .s_axis_text_tdata(tdata), .s_axis_text_tkeep(tkeep), .s_axis_text_tvalid(tvalid),
    .s_axis_text_tready(tready_a), .s_axis_text_tlast(tlast), .s_axis_text_tuser(tuser),
    .allow_sig(allow_a), .deny_sig(deny_a), .match_id(id_a), .match_err(err_a), .ack(ack)
  );

  keyword_match_multi #(.CASE_INSENSITIVE(0)) dut_cs (
    .clk(clk), .reset_n(reset_n), .keywords(keywords), .kw_enable(kw_enable),
    .s_axis_text_tdata(tdata), .s_axis_text_tkeep(tkeep), .s_axis_text_tvalid(tvalid),
    .s_axis_text_tready(tready_b), .s_axis_text_tlast(tlast), .s_axis_text_tuser(tuser),
    .allow_sig(allow_b), .deny_sig(deny_b), .match_id(id_b), .match_err(err_b), .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk_kw(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[(15-i)*8 +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [63:0] mk_beat(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string s, input logic [7:0] k, input logic l, input logic u);
    int waitc;
    tdata  = mk_beat(s);
    tkeep  = k;
    tlast  = l;
    tuser  = u;
    tvalid = 1'b1;
    waitc  = 0;
    while (tready_a !== 1'b1 && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (waitc >= 100) chk("tready_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    tkeep  = 8'h00;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    tdata     = 64'd0;
    tkeep     = 8'h00;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    tuser     = 1'b0;
    ack       = 1'b0;
    kw_enable = 4'b0000;
    keywords  = {mk_kw("b"), mk_kw("abcdefghijklmno"), mk_kw("aab"), mk_kw("secret")};

    #12;
    chk("rst_tready", 32'(tready_a), 32'd0);
    chk("rst_allow",  32'(allow_a),  32'd0);
    chk("rst_deny",   32'(deny_a),   32'd0);
    chk("rst_err",    32'(err_a),    32'd0);
    chk("rst_id",     32'(id_a),     32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_tready", 32'(tready_a), 32'd1);

    // "secret" split across two beats, ack while draining
    kw_enable = 4'b0001;
    send("xxsecre", 8'h7F, 1'b0, 1'b0);
    chk("t1_nodeny_b1", 32'(deny_a), 32'd0);
    send("t yyyyy", 8'h7F, 1'b0, 1'b0);
    chk("t1_deny",   32'(deny_a),   32'd1);
    chk("t1_id",     32'(id_a),     32'd0);
    chk("t1_err",    32'(err_a),    32'd0);
    chk("t1_allow",  32'(allow_a),  32'd0);
    chk("t1_drain_tready", 32'(tready_a), 32'd1);
    do_ack();
    chk("t1_ack_clear", 32'(deny_a), 32'd0);
    chk("t1_still_drain", 32'(tready_a), 32'd1);
    send("zzz", 8'h07, 1'b1, 1'b0);
    chk("t1_idle_tready", 32'(tready_a), 32'd1);
    chk("t1_no_verdict", 32'({allow_a, deny_a}), 32'd0);

    // 15-byte keyword over 3 beats, uppercase text, with tvalid gaps
    kw_enable = 4'b0100;
    send("zzzzzzzA", 8'hFF, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send("BCDEFGHI", 8'hFF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send("JKLMNOzz", 8'hFF, 1'b1, 1'b0);
    chk("t2_ci_deny",  32'(deny_a),  32'd1);
    chk("t2_ci_id",    32'(id_a),    32'd2);
    chk("t2_cs_allow", 32'(allow_b), 32'd1);
    chk("t2_cs_deny",  32'(deny_b),  32'd0);
    chk("t2_hold_tready", 32'(tready_a), 32'd0);
    do_ack();
    chk("t2_clear", 32'({allow_a, deny_a, allow_b, deny_b}), 32'd0);

    // self-overlapping "aab" plus "b" at the same lane: lowest index wins
    kw_enable = 4'b1010;
    send("xaaabyy", 8'h7F, 1'b1, 1'b0);
    chk("t3_deny",  32'(deny_a), 32'd1);
    chk("t3_id",    32'(id_a),   32'd1);
    chk("t3_hold",  32'(tready_a), 32'd0);
    do_ack();

    // keep-masked tail then "ret" in the next frame: no match either way
    kw_enable = 4'b0001;
    send("secret!!", 8'h07, 1'b1, 1'b0);
    chk("t4a_allow", 32'(allow_a), 32'd1);
    chk("t4a_deny",  32'(deny_a),  32'd0);
    do_ack();
    send("ret", 8'h07, 1'b1, 1'b0);
    chk("t4b_allow", 32'(allow_a), 32'd1);
    chk("t4b_deny",  32'(deny_a),  32'd0);
    chk("t4b_id",    32'(id_a),    32'd0);
    do_ack();

    // no active keywords, tuser on beat 2
    kw_enable = 4'b0000;
    send("xxsecret", 8'hFF, 1'b0, 1'b0);
    chk("t5_pending", 32'({allow_a, deny_a}), 32'd0);
    send("abababab", 8'hFF, 1'b0, 1'b1);
    chk("t5_deny", 32'(deny_a), 32'd1);
    chk("t5_err",  32'(err_a),  32'd1);
    chk("t5_id",   32'(id_a),   32'd0);
    send("zz", 8'h03, 1'b1, 1'b0);
    chk("t5_hold", 32'(tready_a), 32'd0);
    chk("t5_held_deny", 32'(deny_a), 32'd1);
    do_ack();
    chk("t5_err_clear", 32'(err_a), 32'd0);

    // same frame without tuser: allow held until ack
    send("xxsecret", 8'hFF, 1'b0, 1'b0);
    send("abababab", 8'hFF, 1'b0, 1'b0);
    send("zz", 8'h03, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5b_allow", 32'(allow_a), 32'd1);
    chk("t5b_hold",  32'(tready_a), 32'd0);
    do_ack();
    chk("t5b_clear", 32'(allow_a), 32'd0);
    chk("t5b_idle",  32'(tready_a), 32'd1);

    // tuser beats a keyword match for match_id
    kw_enable = 4'b1000;
    send("b", 8'h01, 1'b1, 1'b1);
    chk("t5c_err", 32'(err_a), 32'd1);
    chk("t5c_id",  32'(id_a),  32'd0);
    do_ack();

    // reset mid-drain, then a fresh frame
    kw_enable = 4'b0001;
    send("secretzz", 8'hFF, 1'b0, 1'b0);
    chk("t6_deny", 32'(deny_a), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_deny",   32'(deny_a),   32'd0);
    chk("t6_async_tready", 32'(tready_a), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send("secret", 8'h3F, 1'b1, 1'b0);
    chk("t6_new_deny", 32'(deny_a), 32'd1);
    chk("t6_new_id",   32'(id_a),   32'd0);
    chk("t6_new_hold", 32'(tready_a), 32'd0);
    do_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
